// File: rtl/digit_serial_addsub_if.sv
// Handshake/operand bus for digit_serial_addsub.
//   master: drives start, mode, a, b, cin; observes busy, done, result, cout, ovf
//   slave : the arithmetic unit side
interface digit_serial_addsub_if #(
  parameter int G = 32
);
  logic         start;
  logic         mode;
  logic [G-1:0] a;
  logic [G-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [G-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial G-bit adder/subtractor, D bits per clock, LSB digit first.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of digit_serial_addsub_if:
//           start/mode/a/b/cin in; busy/done/result/cout/ovf out
// mode=0: result = a + b + cin, cout = carry-out
// mode=1: result = a - b - cin, cout = borrow-out
// done pulses for one cycle N = G/D edges after start is accepted.
module digit_serial_addsub #(
  parameter int G = 32,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_addsub_if.slave bus
);
  localparam int N  = G / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [G-1:0]  a_q;
  logic [G-1:0]  b_q;
  logic [G-1:0]  shadow;
  logic          mode_q;
  logic          carry;

  logic [D-1:0]  da;
  logic [D-1:0]  db;
  logic [D-1:0]  dsum;
  logic [D:0]    c;
  logic [G-1:0]  final_res;
  logic          last;

  // Subtract uses a + ~b + ~cin; the inverted cin is folded into carry at accept.
  always_comb begin
    da = a_q[cnt*D +: D];
    db = b_q[cnt*D +: D] ^ {D{mode_q}};
  end

  assign c[0] = carry;

  for (genvar i = 0; i < D; i++) begin : g_fa
    assign dsum[i] = da[i] ^ db[i] ^ c[i];
    assign c[i+1]  = (da[i] & db[i]) | (c[i] & (da[i] ^ db[i]));
  end

  assign last = (cnt == CW'(N - 1));

  // Full word as it stands once the current (final) digit is merged in.
  always_comb begin
    final_res = shadow;
    final_res[cnt*D +: D] = dsum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      shadow     <= '0;
      mode_q     <= 1'b0;
      carry      <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            mode_q   <= bus.mode;
            carry    <= bus.cin ^ bus.mode;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          shadow[cnt*D +: D] <= dsum;
          carry              <= c[D];
          cnt                <= cnt + 1'b1;
          if (last) begin
            bus.result <= final_res;
            bus.cout   <= c[D] ^ mode_q;
            bus.ovf    <= (a_q[G-1] == (b_q[G-1] ^ mode_q)) &&
                          (final_res[G-1] != a_q[G-1]);
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
